// File: rtl/zeroheti_pkg.sv
// Shared types and constants for the zeroHETI core-local interrupt controller.
// Register map offsets, attribute layout and trigger encodings live here.
package zeroheti_pkg;

   localparam logic [15:0] ClicCfgOffs = 16'h0000;
   localparam logic [15:0] ClicIrqOffs = 16'h1000;
   localparam int          ClicLevelW  = 8;
   localparam logic [3:0]  ClicNlBits  = 4'd8;

   typedef enum logic [1:0] {
      TrigLevel    = 2'b00,
      TrigRise     = 2'b01,
      TrigLevelAlt = 2'b10,
      TrigFall     = 2'b11
   } clic_trig_e;

   typedef struct packed {
      logic [1:0] priv;
      logic [1:0] rsvd;
      logic       pcs;
      clic_trig_e trig;
      logic       shv;
   } clic_attr_t;

   // Sanitise a written attr byte: reserved bits read as zero, priv 2'b10 maps to machine.
   function automatic clic_attr_t clic_attr_wr(input logic [7:0] b, input logic pcs_en);
      clic_attr_t a;
      a      = clic_attr_t'(b);
      a.rsvd = 2'b00;
      if (!pcs_en) a.pcs = 1'b0;
      if (a.priv == 2'b10) a.priv = 2'b11;
      return a;
   endfunction

endpackage

// File: rtl/zeroheti_clic_arb.sv
// Combinational binary max-tree over {level, id}; ties resolve toward the higher id.
// Leaves beyond NumIrqs are padded as invalid so the tree is always a full power of two.
module zeroheti_clic_arb
   import zeroheti_pkg::*;
#(
   parameter int NumIrqs = 64,
   parameter int IdW     = $clog2(NumIrqs)
) (
   input  logic [NumIrqs-1:0]    line_valid,
   input  logic [ClicLevelW-1:0] line_level [NumIrqs],
   output logic                  win_valid,
   output logic [IdW-1:0]        win_id,
   output logic [ClicLevelW-1:0] win_level
);

   localparam int Leaves = 1 << IdW;

   for (genvar s = 0; s <= IdW; s++) begin : g_stage
      localparam int N = Leaves >> s;
      logic [N-1:0]            v;
      logic [ClicLevelW-1:0]   lvl [N];
      logic [IdW-1:0]          id  [N];

      for (genvar j = 0; j < N; j++) begin : g_node
         if (s == 0) begin : g_leaf
            if (j < NumIrqs) begin : g_real
               assign v[j]   = line_valid[j];
               assign lvl[j] = line_level[j];
            end else begin : g_pad
               assign v[j]   = 1'b0;
               assign lvl[j] = '0;
            end
            assign id[j] = IdW'(j);
         end else begin : g_merge
            logic take_hi;
            // The odd child always covers higher ids, so >= implements the tie rule.
            assign take_hi = g_stage[s-1].v[2*j+1] &&
                             (!g_stage[s-1].v[2*j] ||
                              (g_stage[s-1].lvl[2*j+1] >= g_stage[s-1].lvl[2*j]));
            assign v[j]   = g_stage[s-1].v[2*j] | g_stage[s-1].v[2*j+1];
            assign lvl[j] = take_hi ? g_stage[s-1].lvl[2*j+1] : g_stage[s-1].lvl[2*j];
            assign id[j]  = take_hi ? g_stage[s-1].id[2*j+1]  : g_stage[s-1].id[2*j];
         end
      end
   end

   assign win_valid = g_stage[IdW].v[0];
   assign win_level = g_stage[IdW].lvl[0];
   assign win_id    = g_stage[IdW].id[0];

endmodule

// File: rtl/zeroheti_clic.sv
// CLIC for the zeroHETI core: per-line ip/ie/attr/ctl, max-level arbitration, registered irq outputs.
// Define ZEROHETI_CLIC_PCS_EN to store attr[3] and drive irq_is_pcs_o; otherwise it is RAZ/WI and tied 0.
module zeroheti_clic
   import zeroheti_pkg::*;
#(
   parameter int NumIrqs = 64,
   parameter int AddrW   = 16,
   parameter int IdW     = $clog2(NumIrqs)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NumIrqs-1:0]    irq_src_i,
   input  logic                  reg_req_i,
   input  logic                  reg_we_i,
   input  logic [3:0]            reg_be_i,
   input  logic [AddrW-1:0]      reg_addr_i,
   input  logic [31:0]           reg_wdata_i,
   output logic                  reg_gnt_o,
   output logic                  reg_rvalid_o,
   output logic [31:0]           reg_rdata_o,
   output logic                  irq_o,
   output logic [IdW-1:0]        irq_id_o,
   output logic [ClicLevelW-1:0] irq_level_o,
   output logic                  irq_shv_o,
   output logic [1:0]            irq_priv_o,
   output logic                  irq_is_pcs_o,
   input  logic                  irq_ack_i,
   input  logic [IdW-1:0]        irq_ack_id_i
);

`ifdef ZEROHETI_CLIC_PCS_EN
   localparam logic PcsEn = 1'b1;
`else
   localparam logic PcsEn = 1'b0;
`endif

   logic [NumIrqs-1:0]    line_valid;
   logic [ClicLevelW-1:0] line_level [NumIrqs];
   clic_attr_t            line_attr  [NumIrqs];
   logic [31:0]           line_word  [NumIrqs];

   logic [AddrW-1:0]      offs;
   logic [IdW-1:0]        line_idx;
   logic                  line_hit, cfg_hit, wr;
   logic [31:0]           rd_data;
   logic                  win_valid;
   logic [IdW-1:0]        win_id;
   logic [ClicLevelW-1:0] win_level;
   logic                  unused_wdata;

   assign offs     = reg_addr_i - AddrW'(ClicIrqOffs);
   assign line_idx = offs[IdW+1:2];
   assign line_hit = (reg_addr_i >= AddrW'(ClicIrqOffs)) && (offs[1:0] == 2'b00) &&
                     ({2'b00, offs[AddrW-1:2]} < AddrW'(NumIrqs));
   assign cfg_hit  = (reg_addr_i == AddrW'(ClicCfgOffs));
   assign wr       = reg_req_i & reg_we_i;
   assign unused_wdata = ^{reg_wdata_i[7:1], reg_wdata_i[15:9]};

   for (genvar i = 0; i < NumIrqs; i++) begin : g_line
      logic                  ip_q, ie_q, src_q, sel, acked, edge_set, is_level;
      clic_attr_t            attr_q;
      logic [ClicLevelW-1:0] ctl_q;

      assign sel      = wr && line_hit && (line_idx == IdW'(i));
      assign acked    = irq_ack_i && (irq_ack_id_i == IdW'(i));
      assign is_level = (attr_q.trig == TrigLevel) || (attr_q.trig == TrigLevelAlt);

      // NOTE: the default assignment keeps edge_set from becoming a latch for level encodings.
      always_comb begin
         edge_set = 1'b0;
         case (attr_q.trig)
            TrigRise: edge_set = irq_src_i[i] & ~src_q;
            TrigFall: edge_set = ~irq_src_i[i] & src_q;
            default:  edge_set = 1'b0;
         endcase
      end

      // NOTE: per-line state is plain flops, so it is reset like any other register.
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            ip_q   <= 1'b0;
            ie_q   <= 1'b0;
            src_q  <= 1'b0;
            attr_q <= '0;
            ctl_q  <= '0;
         end else begin
            src_q <= irq_src_i[i];
            if (is_level)                 ip_q <= irq_src_i[i];
            else if (edge_set)            ip_q <= 1'b1;
            else if (acked)               ip_q <= 1'b0;
            else if (sel && reg_be_i[0])  ip_q <= reg_wdata_i[0];
            if (sel && reg_be_i[1]) ie_q   <= reg_wdata_i[8];
            if (sel && reg_be_i[2]) attr_q <= clic_attr_wr(reg_wdata_i[23:16], PcsEn);
            if (sel && reg_be_i[3]) ctl_q  <= reg_wdata_i[31:24];
         end
      end

      assign line_valid[i] = ip_q & ie_q & (ctl_q != '0);
      assign line_level[i] = ctl_q;
      assign line_attr[i]  = attr_q;
      assign line_word[i]  = {ctl_q, attr_q, 7'b0, ie_q, 7'b0, ip_q};
   end

   zeroheti_clic_arb #(
      .NumIrqs (NumIrqs),
      .IdW     (IdW)
   ) u_arb (
      .line_valid (line_valid),
      .line_level (line_level),
      .win_valid  (win_valid),
      .win_id     (win_id),
      .win_level  (win_level)
   );

   always_comb begin
      rd_data = '0;
      if (cfg_hit)       rd_data = {27'b0, ClicNlBits, 1'b0};
      else if (line_hit) rd_data = line_word[line_idx];
   end

   assign reg_gnt_o = reg_req_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         reg_rvalid_o <= 1'b0;
         reg_rdata_o  <= '0;
      end else begin
         reg_rvalid_o <= reg_req_i;
         if (reg_req_i) reg_rdata_o <= reg_we_i ? 32'h0 : rd_data;
      end
   end

   // Sideband fields hold their last value while no line is eligible.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         irq_o       <= 1'b0;
         irq_id_o    <= '0;
         irq_level_o <= '0;
         irq_shv_o   <= 1'b0;
         irq_priv_o  <= 2'b11;
      end else if (win_valid) begin
         irq_o       <= 1'b1;
         irq_id_o    <= win_id;
         irq_level_o <= win_level;
         irq_shv_o   <= line_attr[win_id].shv;
         irq_priv_o  <= line_attr[win_id].priv;
      end else begin
         irq_o       <= 1'b0;
      end
   end

`ifdef ZEROHETI_CLIC_PCS_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)          irq_is_pcs_o <= 1'b0;
      else if (win_valid) irq_is_pcs_o <= line_attr[win_id].pcs;
   end
`else
   assign irq_is_pcs_o = 1'b0;
`endif

endmodule

// File: tb/tb_zeroheti_clic.sv
// Directed self-checking bench for zeroheti_clic with hand-computed expectations.
// Build with ZEROHETI_CLIC_PCS_EN defined to exercise the pcs path.
module tb_zeroheti_clic;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] src = '0;
   logic        req = 1'b0, we = 1'b0;
   logic [3:0]  be = '0;
   logic [15:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        gnt, rvalid;
   logic [31:0] rdata;
   logic        irq, shv, is_pcs;
   logic [5:0]  id;
   logic [7:0]  level;
   logic [1:0]  priv;
   logic        ack = 1'b0;
   logic [5:0]  ack_id = '0;

   int passed = 0;
   int total  = 0;

`ifdef ZEROHETI_CLIC_PCS_EN
   localparam logic [31:0] L20Word = 32'h10C9_0101;
   localparam logic        PcsExp  = 1'b1;
`else
   localparam logic [31:0] L20Word = 32'h10C1_0101;
   localparam logic        PcsExp  = 1'b0;
`endif

   zeroheti_clic dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .irq_src_i    (src),
      .reg_req_i    (req),
      .reg_we_i     (we),
      .reg_be_i     (be),
      .reg_addr_i   (addr),
      .reg_wdata_i  (wdata),
      .reg_gnt_o    (gnt),
      .reg_rvalid_o (rvalid),
      .reg_rdata_o  (rdata),
      .irq_o        (irq),
      .irq_id_o     (id),
      .irq_level_o  (level),
      .irq_shv_o    (shv),
      .irq_priv_o   (priv),
      .irq_is_pcs_o (is_pcs),
      .irq_ack_i    (ack),
      .irq_ack_id_i (ack_id)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic reg_wr(input logic [15:0] a, input logic [3:0] b, input logic [31:0] d);
      req = 1'b1; we = 1'b1; addr = a; be = b; wdata = d;
      #1;
      check("gnt", 32'(gnt), 32'd1);
      @(posedge clk);
      #1;
      req = 1'b0; we = 1'b0;
      check("rvalid_wr", 32'(rvalid), 32'd1);
   endtask

   task automatic rd_chk(input string tag, input logic [15:0] a, input logic [31:0] exp);
      req = 1'b1; we = 1'b0; addr = a; be = 4'hF;
      @(posedge clk);
      #1;
      req = 1'b0;
      check(tag, rdata, exp);
   endtask

   initial begin
      // Reset state
      step(2);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_priv", 32'(priv), 32'd3);
      check("rst_id", 32'(id), 32'd0);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      rst = 1'b0;
      step(1);
      rd_chk("rst_line1", 16'h1004, 32'h0);
      rd_chk("cliccfg", 16'h0000, 32'h0000_0010);

      // Level line 3
      reg_wr(16'h100C, 4'b1110, 32'h4000_0100);
      src[3] = 1'b1;
      step(1);
      check("lvl3_lat", 32'(irq), 32'd0);
      step(1);
      check("lvl3_irq", 32'(irq), 32'd1);
      check("lvl3_id", 32'(id), 32'd3);
      check("lvl3_level", 32'(level), 32'h40);
      check("lvl3_priv", 32'(priv), 32'd0);
      src[3] = 1'b0;
      step(1);
      check("lvl3_fall1", 32'(irq), 32'd1);
      step(1);
      check("lvl3_fall2", 32'(irq), 32'd0);
      check("lvl3_hold", 32'(id), 32'd3);
      reg_wr(16'h100C, 4'b0001, 32'h0000_0001);
      rd_chk("lvl3_swip", 16'h100C, 32'h4000_0100);

      // Arbitration: 2 (0xC0) beats 5/9 (0x80); then tie goes to 9
      reg_wr(16'h1008, 4'b1110, 32'hC000_0100);
      reg_wr(16'h1014, 4'b1110, 32'h8000_0100);
      reg_wr(16'h1024, 4'b1110, 32'h8000_0100);
      src[2] = 1'b1; src[5] = 1'b1; src[9] = 1'b1;
      step(2);
      check("arb_id2", 32'(id), 32'd2);
      check("arb_lvl2", 32'(level), 32'hC0);
      src[2] = 1'b0;
      step(2);
      check("arb_tie_id", 32'(id), 32'd9);
      check("arb_tie_lvl", 32'(level), 32'h80);
      src[5] = 1'b0; src[9] = 1'b0;
      step(2);
      check("arb_none", 32'(irq), 32'd0);

      // Rising-edge line 7
      reg_wr(16'h101C, 4'b1110, 32'h2002_0100);
      src[7] = 1'b1;
      step(1);
      src[7] = 1'b0;
      step(1);
      check("edge7_irq", 32'(irq), 32'd1);
      check("edge7_id", 32'(id), 32'd7);
      rd_chk("edge7_ip", 16'h101C, 32'h2002_0101);
      ack = 1'b1; ack_id = 6'd7;
      step(1);
      ack = 1'b0;
      check("edge7_ackwin", 32'(irq), 32'd1);
      step(1);
      check("edge7_ackirq", 32'(irq), 32'd0);
      rd_chk("edge7_ackip", 16'h101C, 32'h2002_0100);
      src[7] = 1'b1;
      step(1);
      src[7] = 1'b0;
      step(1);
      src[7] = 1'b1; ack = 1'b1; ack_id = 6'd7;
      step(1);
      src[7] = 1'b0; ack = 1'b0;
      rd_chk("edge7_race", 16'h101C, 32'h2002_0101);
      ack = 1'b1;
      step(1);
      ack = 1'b0;
      rd_chk("edge7_clr", 16'h101C, 32'h2002_0100);
      reg_wr(16'h101C, 4'b0001, 32'h0000_0001);
      rd_chk("edge7_swset", 16'h101C, 32'h2002_0101);
      reg_wr(16'h101C, 4'b0001, 32'h0000_0000);
      rd_chk("edge7_swclr", 16'h101C, 32'h2002_0100);

      // Falling-edge line 11
      reg_wr(16'h102C, 4'b0100, 32'h0006_0000);
      src[11] = 1'b1;
      step(1);
      rd_chk("fall11_rise", 16'h102C, 32'h0006_0000);
      src[11] = 1'b0;
      step(1);
      rd_chk("fall11_set", 16'h102C, 32'h0006_0001);

      // Register port corners
      reg_wr(16'h1010, 4'b1000, 32'hFF00_0000);
      rd_chk("ctl4", 16'h1010, 32'hFF00_0000);
      reg_wr(16'h1100, 4'b1111, 32'hFFFF_FFFF);
      rd_chk("oob_rd", 16'h1100, 32'h0);
      rd_chk("oob_l63", 16'h10FC, 32'h0);
      rd_chk("oob_l0", 16'h1000, 32'h0);
      reg_wr(16'h1000, 4'b0100, 32'h0080_0000);
      rd_chk("priv10", 16'h1000, 32'h00C0_0000);

      // Line 20 with priv 3, pcs, shv
      reg_wr(16'h1050, 4'b1110, 32'h10C9_0100);
      src[20] = 1'b1;
      step(2);
      check("l20_irq", 32'(irq), 32'd1);
      check("l20_id", 32'(id), 32'd20);
      check("l20_level", 32'(level), 32'h10);
      check("l20_priv", 32'(priv), 32'd3);
      check("l20_shv", 32'(shv), 32'd1);
      check("l20_pcs", 32'(is_pcs), 32'(PcsExp));
      rd_chk("l20_word", 16'h1050, L20Word);

      // Mid-operation reset
      rst = 1'b1;
      #1;
      check("mrst_irq", 32'(irq), 32'd0);
      check("mrst_priv", 32'(priv), 32'd3);
      check("mrst_pcs", 32'(is_pcs), 32'd0);
      src = '0;
      step(1);
      rst = 1'b0;
      step(1);
      rd_chk("mrst_l20", 16'h1050, 32'h0);
      rd_chk("mrst_l11", 16'h102C, 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
